// File: rtl/serial_port_ctrl.sv
// serial_port_ctrl: CPU-side TX/RX FIFO sequencer for one serial_port, with DATA/STATUS registers and level irq.
// Optional loopback (CTRL bit 2, STATUS bit 6) is built only when SERIAL_PORT_CTRL_LOOPBACK_EN is defined.
module serial_port_ctrl #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_en,
  input  logic       bus_we,
  input  logic       bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       irq,
  output logic [7:0] sp_data_in,
  output logic       sp_write_enable,
  input  logic       sp_write_busy,
  input  logic [7:0] sp_data_out,
  input  logic       sp_int_req,
  output logic       sp_int_ack
);
  localparam logic [1:0] TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_GUARD = 2'd2, TX_DRAIN = 2'd3;
  localparam logic [0:0] RX_IDLE = 1'b0, RX_WAIT = 1'b1;
  logic [7:0] tx_mem [1 << TX_DEPTH_LOG2];
  logic [7:0] rx_mem [1 << RX_DEPTH_LOG2];
  logic [TX_DEPTH_LOG2:0] tx_wp, tx_rp;
  logic [RX_DEPTH_LOG2:0] rx_wp, rx_rp;
  logic [1:0] tx_state;
  logic [0:0] rx_state;
  logic rx_ie, tx_ie, tx_drop, lb_en;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic data_wr, data_rd, ctrl_wr, stat_rd;
  logic tx_push, tx_pop, port_cap, rx_push, rx_pop;
  logic [7:0] tx_head, rx_head, rx_wdata, status;
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[TX_DEPTH_LOG2] != tx_rp[TX_DEPTH_LOG2]) &&
                    (tx_wp[TX_DEPTH_LOG2-1:0] == tx_rp[TX_DEPTH_LOG2-1:0]);
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[RX_DEPTH_LOG2] != rx_rp[RX_DEPTH_LOG2]) &&
                    (rx_wp[RX_DEPTH_LOG2-1:0] == rx_rp[RX_DEPTH_LOG2-1:0]);
  assign tx_idle  = tx_empty && tx_state == TX_IDLE;
  assign tx_head  = tx_mem[tx_rp[TX_DEPTH_LOG2-1:0]];
  assign rx_head  = rx_mem[rx_rp[RX_DEPTH_LOG2-1:0]];
  assign data_wr  = bus_en && bus_we && !bus_addr;
  assign data_rd  = bus_en && !bus_we && !bus_addr;
  assign ctrl_wr  = bus_en && bus_we && bus_addr;
  assign stat_rd  = bus_en && !bus_we && bus_addr;
  // Full/empty are judged on cycle-start pointers, so a same-cycle pop never rescues a push.
  assign tx_push  = data_wr && !tx_full;
  assign tx_pop   = tx_state == TX_IDLE && !tx_empty && (lb_en ? !rx_full : !sp_write_busy);
  assign port_cap = rx_state == RX_IDLE && sp_int_req && !rx_full && !lb_en;
  assign rx_push  = (tx_pop && lb_en) || port_cap;
  assign rx_pop   = data_rd && !rx_empty;
  assign rx_wdata = lb_en ? tx_head : sp_data_out;
  assign status   = {1'b0, lb_en, tx_drop, tx_ie, rx_ie, tx_idle, !tx_full, !rx_empty};
  assign sp_write_enable = tx_state == TX_SEND;
`ifdef SERIAL_PORT_CTRL_LOOPBACK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) lb_en <= 1'b0;
    else if (ctrl_wr) lb_en <= bus_wdata[2];
`else
  assign lb_en = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TX_DEPTH_LOG2-1:0]] <= bus_wdata;
    if (rx_push) rx_mem[rx_wp[RX_DEPTH_LOG2-1:0]] <= rx_wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp      <= '0;
      tx_rp      <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      tx_state   <= TX_IDLE;
      rx_state   <= RX_IDLE;
      sp_data_in <= 8'h00;
      sp_int_ack <= 1'b0;
      bus_rdata  <= 8'h00;
      irq        <= 1'b0;
      rx_ie      <= 1'b0;
      tx_ie      <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      tx_wp <= tx_wp + (TX_DEPTH_LOG2+1)'(tx_push);
      tx_rp <= tx_rp + (TX_DEPTH_LOG2+1)'(tx_pop);
      rx_wp <= rx_wp + (RX_DEPTH_LOG2+1)'(rx_push);
      rx_rp <= rx_rp + (RX_DEPTH_LOG2+1)'(rx_pop);
      tx_state <= tx_state == TX_IDLE  ? ((tx_pop && !lb_en) ? TX_SEND : TX_IDLE) :
                  tx_state == TX_SEND  ? TX_GUARD :
                  tx_state == TX_GUARD ? TX_DRAIN :
                  (sp_write_busy ? TX_DRAIN : TX_IDLE);
      if (tx_pop && !lb_en) sp_data_in <= tx_head;
      rx_state   <= rx_state == RX_IDLE ? (port_cap ? RX_WAIT : RX_IDLE) : (sp_int_req ? RX_WAIT : RX_IDLE);
      sp_int_ack <= port_cap;
      if (data_rd) bus_rdata <= rx_empty ? 8'h00 : rx_head;
      else if (stat_rd) bus_rdata <= status;
      tx_drop <= (data_wr && tx_full) || (tx_drop && !stat_rd);
      if (ctrl_wr) begin
        rx_ie <= bus_wdata[0];
        tx_ie <= bus_wdata[1];
      end
      irq <= (rx_ie && !rx_empty) || (tx_ie && tx_idle);
    end
  end
endmodule
